program_loader: RTL and testbench

//  Boot-time loader upstream of the instruction memory. Takes a byte stream over a

---
 rtl/program_loader.sv | 219 +++++++++++++++++++++
 tb/tb_program_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------------------------
// program_loader
//
// Boot-time loader in front of the instruction memory. It receives a byte stream over a
// valid/ready handshake and packs the bytes into 32-bit little-endian words. The words are
// written to instruction memory starting at address 0. The processor is held in reset for
// the whole load and is released once the program has been committed.
//
// Frame on the byte stream:
//   LEN_LO, LEN_HI      program length N in words (16-bit, little-endian)
//   4*N data bytes      little-endian within each word
//   CSUM                one byte, present only when PROGRAM_LOADER_CSUM_EN is defined
//
// Optional feature macro:
//   PROGRAM_LOADER_CSUM_EN  When defined, the loader keeps a mod-256 sum of the data bytes.
//                           The trailing byte must equal that sum, otherwise the load ends
//                           in the error state.
//
// Parameters:
//   MAX_WORDS     largest accepted program length in words (<= 65535)
//   CNT_W         width of the word index / counter; 2**CNT_W must exceed MAX_WORDS
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high; restarts the load
//   rx_valid      byte on rx_data is valid
//   rx_data       incoming byte
//   rx_ready      loader accepts a byte (transfer = rx_valid & rx_ready)
//   imem_we       one-cycle instruction-memory write strobe
//   imem_addr     word-aligned byte address of the write (4 * index)
//   imem_wdata    word to write
//   cpu_reset     processor reset; high until the program is running
//   load_done     high once the program is committed and running
//   load_error    high in the error state, sticky until reset
//   words_loaded  number of words written so far
//
// All outputs are registered.
// ---------------------------------------------------------------------------------------------
module program_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned CNT_W     = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             cpu_reset,
    output logic             load_done,
    output logic             load_error,
    output logic [CNT_W-1:0] words_loaded
);

`ifdef PROGRAM_LOADER_CSUM_EN
    typedef enum logic [2:0] {
        StLen0, StLen1, StData, StCsum, StCommit, StRun, StErr
    } state_e;
`else
    typedef enum logic [2:0] {
        StLen0, StLen1, StData, StCommit, StRun, StErr
    } state_e;
`endif

    state_e           state_q;
    logic [7:0]       len_lo_q;
    logic [15:0]      len_q;
    logic [CNT_W-1:0] idx_q;
    logic [1:0]       lane_q;
    logic [23:0]      word_q;     // lanes 0..2; lane 3 arrives with the write itself
`ifdef PROGRAM_LOADER_CSUM_EN
    logic [7:0]       sum_q;
`endif

    logic        xfer;
    logic [15:0] len_in;
    logic        too_long;
    logic        last_word;

    assign xfer      = rx_valid & rx_ready;
    assign len_in    = {rx_data, len_lo_q};
    assign too_long  = 32'(len_in) > MAX_WORDS;
    // idx_q is the index of the word being completed on this transfer
    assign last_word = (32'(idx_q) + 32'd1) == 32'(len_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StLen0;
            len_lo_q     <= 8'd0;
            len_q        <= 16'd0;
            idx_q        <= '0;
            lane_q       <= 2'd0;
            word_q       <= 24'd0;
`ifdef PROGRAM_LOADER_CSUM_EN
            sum_q        <= 8'd0;
`endif
            rx_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= 32'd0;
            imem_wdata   <= 32'd0;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;

            unique case (state_q)
                StLen0: begin
                    // rx_ready comes up on the first clock after reset release
                    rx_ready <= 1'b1;
                    if (xfer) begin
                        len_lo_q <= rx_data;
                        state_q  <= StLen1;
                    end
                end

                StLen1: begin
                    if (xfer) begin
                        len_q  <= len_in;
                        idx_q  <= '0;
                        lane_q <= 2'd0;
`ifdef PROGRAM_LOADER_CSUM_EN
                        sum_q  <= 8'd0;
`endif
                        if (too_long) begin
                            rx_ready   <= 1'b0;
                            load_error <= 1'b1;
                            state_q    <= StErr;
                        end else if (len_in == 16'd0) begin
`ifdef PROGRAM_LOADER_CSUM_EN
                            state_q  <= StCsum;
`else
                            rx_ready <= 1'b0;
                            state_q  <= StCommit;
`endif
                        end else begin
                            state_q <= StData;
                        end
                    end
                end

                StData: begin
                    if (xfer) begin
`ifdef PROGRAM_LOADER_CSUM_EN
                        sum_q  <= sum_q + rx_data;
`endif
                        lane_q <= lane_q + 2'd1;
                        unique case (lane_q)
                            2'd0: word_q[7:0]   <= rx_data;
                            2'd1: word_q[15:8]  <= rx_data;
                            2'd2: word_q[23:16] <= rx_data;
                            2'd3: begin
                                imem_we      <= 1'b1;
                                imem_addr    <= 32'({idx_q, 2'b00});
                                imem_wdata   <= {rx_data, word_q};
                                words_loaded <= idx_q + CNT_W'(1);
                                idx_q        <= idx_q + CNT_W'(1);
                                if (last_word) begin
`ifdef PROGRAM_LOADER_CSUM_EN
                                    state_q  <= StCsum;
`else
                                    rx_ready <= 1'b0;
                                    state_q  <= StCommit;
`endif
                                end
                            end
                            default: ;
                        endcase
                    end
                end

`ifdef PROGRAM_LOADER_CSUM_EN
                StCsum: begin
                    if (xfer) begin
                        rx_ready <= 1'b0;
                        if (rx_data == sum_q) begin
                            state_q <= StCommit;
                        end else begin
                            load_error <= 1'b1;
                            state_q    <= StErr;
                        end
                    end
                end
`endif

                // One idle cycle so the final write strobe has retired before the CPU runs
                StCommit: begin
                    rx_ready  <= 1'b0;
                    cpu_reset <= 1'b0;
                    load_done <= 1'b1;
                    state_q   <= StRun;
                end

                StRun: begin
                    rx_ready  <= 1'b0;
                    cpu_reset <= 1'b0;
                    load_done <= 1'b1;
                end

                StErr: begin
                    rx_ready   <= 1'b0;
                    cpu_reset  <= 1'b1;
                    load_error <= 1'b1;
                end

                default: begin
                    rx_ready   <= 1'b0;
                    cpu_reset  <= 1'b1;
                    load_error <= 1'b1;
                    state_q    <= StErr;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int unsigned CNT_W = 9;

    logic             clk;
    logic             reset;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic             imem_we;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_wdata;
    logic             cpu_reset;
    logic             load_done;
    logic             load_error;
    logic [CNT_W-1:0] words_loaded;

    program_loader #(
        .MAX_WORDS (256),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q [$];
    int          checks   = 0;
    int          errors   = 0;
    int          we_count = 0;
    int          w0;
    logic [7:0]  prog     [8];
    logic [31:0] exp_word [2];
    logic [7:0]  csum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                we_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                             imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", imem_addr, e.addr);
                    check("write_data", imem_wdata, e.data);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the transfer edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (rx_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_byte: rx_ready got %b, expected 1 within 20 cycles", rx_ready);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    // Sends LEN=2 and the first nbytes data bytes, queuing each completed word
    task automatic send_frame(input int gap, input int nbytes);
        send_byte(8'h02, gap);
        send_byte(8'h00, gap);
        for (int i = 0; i < nbytes; i++) begin
            if (i % 4 == 3) exp_q.push_back('{addr: 32'(i / 4 * 4), data: exp_word[i / 4]});
            send_byte(prog[i], gap);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // After the final frame byte: one COMMIT cycle, then RUN
    task automatic check_run(input string tag);
        check({tag, " commit_done"}, 32'(load_done), 32'd0);
        check({tag, " commit_cpu_reset"}, 32'(cpu_reset), 32'd1);
        @(negedge clk);
        check({tag, " load_done"}, 32'(load_done), 32'd1);
        check({tag, " cpu_reset"}, 32'(cpu_reset), 32'd0);
        check({tag, " load_error"}, 32'(load_error), 32'd0);
        check({tag, " rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, " words_loaded"}, 32'(words_loaded), 32'd2);
        check({tag, " write_count"}, 32'(we_count - w0), 32'd2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        prog     = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        exp_word = '{32'h00100513, 32'h00200593};
        csum     = 8'd0;
        for (int i = 0; i < 8; i++) csum = csum + prog[i];

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst rx_ready", 32'(rx_ready), 32'd0);
        check("rst imem_we", 32'(imem_we), 32'd0);
        check("rst imem_addr", imem_addr, 32'd0);
        check("rst imem_wdata", imem_wdata, 32'd0);
        check("rst cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst load_done", 32'(load_done), 32'd0);
        check("rst load_error", 32'(load_error), 32'd0);
        check("rst words_loaded", 32'(words_loaded), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst rx_ready", 32'(rx_ready), 32'd1);

        // Test 1: back-to-back N=2 load
        w0 = we_count;
        send_frame(0, 8);
`ifdef PROGRAM_LOADER_CSUM_EN
        send_byte(csum, 0);
`endif
        check_run("t1");
        // Bytes offered in RUN are refused
        rx_valid = 1'b1;
        rx_data  = 8'hff;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        check("t1 run_rx_ready", 32'(rx_ready), 32'd0);
        check("t1 run_no_write", 32'(we_count - w0), 32'd2);

        // Test 2: three idle cycles before every byte
        do_reset();
        w0 = we_count;
        send_frame(3, 8);
`ifdef PROGRAM_LOADER_CSUM_EN
        send_byte(csum, 3);
`endif
        check_run("t2");

        // Test 3: N=257 exceeds MAX_WORDS
        do_reset();
        w0 = we_count;
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("t3 load_error", 32'(load_error), 32'd1);
        check("t3 rx_ready", 32'(rx_ready), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        check("t3 cpu_reset", 32'(cpu_reset), 32'd1);
        check("t3 load_done", 32'(load_done), 32'd0);
        check("t3 sticky_error", 32'(load_error), 32'd1);
        check("t3 no_write", 32'(we_count - w0), 32'd0);

        // Test 4: N=0 commits with no writes
        do_reset();
        w0 = we_count;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef PROGRAM_LOADER_CSUM_EN
        send_byte(8'h00, 0);
`endif
        check("t4 commit_done", 32'(load_done), 32'd0);
        @(negedge clk);
        check("t4 load_done", 32'(load_done), 32'd1);
        check("t4 cpu_reset", 32'(cpu_reset), 32'd0);
        check("t4 words_loaded", 32'(words_loaded), 32'd0);
        check("t4 no_write", 32'(we_count - w0), 32'd0);

        // Test 5: reset after 5 data bytes, then a full reload
        do_reset();
        w0 = we_count;
        send_frame(0, 5);
        check("t5 partial_writes", 32'(we_count - w0), 32'd1);
        check("t5 partial_words", 32'(words_loaded), 32'd1);
        reset = 1'b1;
        #1;
        check("t5 async_words", 32'(words_loaded), 32'd0);
        check("t5 async_rx_ready", 32'(rx_ready), 32'd0);
        check("t5 async_cpu_reset", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        w0 = we_count;
        send_frame(0, 8);
`ifdef PROGRAM_LOADER_CSUM_EN
        send_byte(csum, 0);
`endif
        check_run("t5");

`ifdef PROGRAM_LOADER_CSUM_EN
        // Test 6: wrong checksum ends in ERR; both words were already written
        do_reset();
        w0 = we_count;
        send_frame(0, 8);
        send_byte(csum + 8'd1, 0);
        @(negedge clk);
        check("t6 load_error", 32'(load_error), 32'd1);
        check("t6 load_done", 32'(load_done), 32'd0);
        check("t6 cpu_reset", 32'(cpu_reset), 32'd1);
        check("t6 writes", 32'(we_count - w0), 32'd2);
`endif

        repeat (2) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
